// File: rtl/arb_pkg.sv
// arb_pkg: shared types and default widths for the cache arbiter
//   arb_state_t : arbiter FSM states
//   req_id_t    : requester identity (instruction or data cache)
//   ADDR_W_DEF / LINE_W_DEF : default address and line widths
package arb_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} arb_state_t;
    typedef enum logic {REQ_I, REQ_D} req_id_t;
endpackage

// File: rtl/arb_grant_select.sv
// arb_grant_select: combinational winner selection between I and D requesters
//   i_req, d_req : requester activity
//   last         : requester granted most recently
//   winner       : requester to grant (meaningful only when a request is active)
// Macro ARB_ROUND_ROBIN_EN: simultaneous requests alternate using last;
// otherwise the data cache always wins a tie.
module arb_grant_select import arb_pkg::*; (
    input  logic    i_req,
    input  logic    d_req,
    input  req_id_t last,
    output req_id_t winner
);
    req_id_t tie_pick;
`ifdef ARB_ROUND_ROBIN_EN
    assign tie_pick = (last == REQ_D) ? REQ_I : REQ_D;
`else
    logic unused_last;
    assign unused_last = last;
    assign tie_pick = REQ_D;
`endif
    assign winner = (i_req && !d_req) ? REQ_I : (d_req && !i_req) ? REQ_D : tie_pick;
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory port between I-cache and D-cache
//   clk, rst_n (async, active-low)
//   i_pmem_*   : I-cache read port (read, address, resp, rdata)
//   d_pmem_*   : D-cache read/writeback port (read, write, address, wdata, resp, rdata)
//   pmem_*     : physical-memory port (read, write, address, wdata, resp, rdata)
// Macro ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests
// (default build: D-cache has fixed priority).
module cache_arbiter import arb_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic              i_pmem_resp,
    output logic [LINE_W-1:0] i_pmem_rdata,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic              d_pmem_resp,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);
    arb_state_t state, next;
    req_id_t    last, winner;
    logic       i_act, d_act;

    assign i_act = i_pmem_read;
    assign d_act = d_pmem_read || d_pmem_write;

    arb_grant_select u_sel (
        .i_req  (i_act),
        .d_req  (d_act),
        .last   (last),
        .winner (winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          last <= REQ_I;
        else if (state == IDLE && (i_act || d_act)) last <= winner;
    end
`else
    assign last = REQ_I;
`endif

    // Outputs decode from state only, so reset zeroes them asynchronously and
    // a stray pmem_resp in IDLE never reaches a requester.
    always_comb begin
        next         = state;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        i_pmem_rdata = '0;
        d_pmem_resp  = 1'b0;
        d_pmem_rdata = '0;
        case (state)
            IDLE: begin
                if (i_act || d_act) next = (winner == REQ_D) ? SERVE_D : SERVE_I;
            end
            SERVE_I: begin
                pmem_read    = i_pmem_read;
                pmem_address = i_pmem_address;
                i_pmem_resp  = pmem_resp;
                i_pmem_rdata = pmem_rdata;
                if (pmem_resp) next = RELEASE;
            end
            SERVE_D: begin
                // a simultaneous read and write forwards only the writeback
                pmem_write   = d_pmem_write;
                pmem_read    = d_pmem_read && !d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
                d_pmem_rdata = pmem_rdata;
                if (pmem_resp) next = RELEASE;
            end
            RELEASE: next = IDLE;
        endcase
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(d_pmem_read && d_pmem_write))
        else $warning("cache_arbiter: D-cache read and write raised together, write forwarded");
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: randomized self-checking bench with a transaction-level model
module tb_cache_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_pmem_read = 1'b0;
    logic [AW-1:0] i_pmem_address = '0;
    logic          i_pmem_resp;
    logic [LW-1:0] i_pmem_rdata;
    logic          d_pmem_read = 1'b0;
    logic          d_pmem_write = 1'b0;
    logic [AW-1:0] d_pmem_address = '0;
    logic [LW-1:0] d_pmem_wdata = '0;
    logic          d_pmem_resp;
    logic [LW-1:0] d_pmem_rdata;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic          pmem_resp = 1'b0;
    logic [LW-1:0] pmem_rdata = '0;

    always #5 clk = ~clk;

    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_resp    (i_pmem_resp),
        .i_pmem_rdata   (i_pmem_rdata),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_resp    (d_pmem_resp),
        .d_pmem_rdata   (d_pmem_rdata),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_resp      (pmem_resp),
        .pmem_rdata     (pmem_rdata)
    );

    int n_tests = 0;
    int n_fail = 0;
    bit last_d = 1'b0;
    bit d_rd_req, d_wr_req;
    logic [LW-1:0] exp_rd;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Arbitration rule at transaction level: lone requester wins; a tie goes to
    // D in fixed priority, or to whoever was not served last in round robin.
    function automatic bit pick_d(input bit i_p, input bit d_p);
        if (!d_p) return 1'b0;
        if (!i_p) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        return !last_d;
`else
        return 1'b1;
`endif
    endfunction

    task automatic drop(input bit is_d);
        if (is_d) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
        else i_pmem_read = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_cmd"}, LW'({pmem_read, pmem_write}), '0);
        check({tag, "_resp"}, LW'({i_pmem_resp, d_pmem_resp}), '0);
    endtask

    task automatic serve(input bit is_d, input int exp_lat, input bit wd, input int dly);
        int n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!(pmem_read || pmem_write) && n < 8);
        check(is_d ? "lat_d" : "lat_i", LW'(n), LW'(exp_lat));
        if (is_d) begin
            check("d_write", LW'(pmem_write), LW'(d_wr_req));
            check("d_read", LW'(pmem_read), LW'(d_rd_req && !d_wr_req));
            check("d_addr", LW'(pmem_address), LW'(d_pmem_address));
            check("d_wdata", pmem_wdata, d_pmem_wdata);
        end else begin
            check("i_cmd", LW'({pmem_read, pmem_write}), LW'(2'b10));
            check("i_addr", LW'(pmem_address), LW'(i_pmem_address));
        end
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            if (wd && k == 0) drop(is_d);
            #1;
            if (wd) check("withdrawn_cmd", LW'({pmem_read, pmem_write}), '0);
            check("early_resp", LW'({i_pmem_resp, d_pmem_resp}), '0);
        end
        @(negedge clk);
        exp_rd = rand_line();
        pmem_resp = 1'b1;
        pmem_rdata = exp_rd;
        #1;
        check("own_resp", LW'({i_pmem_resp, d_pmem_resp}), is_d ? LW'(2'b01) : LW'(2'b10));
        check("own_rdata", is_d ? d_pmem_rdata : i_pmem_rdata, exp_rd);
        check("other_rdata", is_d ? i_pmem_rdata : d_pmem_rdata, '0);
        @(negedge clk);
        pmem_resp = 1'b0;
        drop(is_d);
        #1;
        check_quiet("release");
    endtask

    // dly < 0 picks a random memory delay and may withdraw the owner's request
    task automatic run_round(input bit want_i, input bit want_d, input bit d_rd, input bit d_wr, input int dly);
        bit i_p, d_p, who, first;
        int del;
        @(negedge clk);
        i_pmem_read = want_i;
        d_pmem_read = want_d && d_rd;
        d_pmem_write = want_d && d_wr;
        d_rd_req = d_rd;
        d_wr_req = d_wr;
        i_p = want_i;
        d_p = want_d;
        first = 1'b1;
        while (i_p || d_p) begin
            who = pick_d(i_p, d_p);
            last_d = who;
            del = (dly < 0) ? int'($urandom_range(0, 4)) : dly;
            serve(who, first ? 1 : 2, (dly < 0) && del > 0 && $urandom_range(0, 5) == 0, del);
            if (who) d_p = 1'b0; else i_p = 1'b0;
            first = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_quiet("reset");
        check("reset_addr", LW'(pmem_address), '0);
        rst_n = 1'b1;

        i_pmem_address = 32'h0000_1000;
        run_round(1'b1, 1'b0, 1'b0, 1'b0, 5);

        i_pmem_address = 32'h0000_0100;
        d_pmem_address = 32'h0000_0200;
        d_pmem_wdata = rand_line();
        run_round(1'b1, 1'b1, 1'b0, 1'b1, 2);

        repeat (3) begin
            i_pmem_address = $urandom;
            d_pmem_address = $urandom;
            d_pmem_wdata = rand_line();
            run_round(1'b1, 1'b1, 1'b1, 1'b0, 1);
        end

        d_pmem_address = 32'h0000_0300;
        d_pmem_wdata = rand_line();
        run_round(1'b0, 1'b1, 1'b1, 1'b1, 1);

        // reset two cycles into SERVE_D abandons the transaction
        @(negedge clk);
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h0000_0400;
        d_pmem_wdata = rand_line();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_reset_write", LW'(pmem_write), LW'(1'b1));
        rst_n = 1'b0;
        #1;
        check_quiet("async_reset");
        check("async_reset_wdata", pmem_wdata, '0);
        @(negedge clk);
        rst_n = 1'b1;
        d_pmem_write = 1'b0;
        last_d = 1'b0;
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        check("stale_resp", LW'(d_pmem_resp), '0);
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        check_quiet("after_stale");

        for (int r = 0; r < 40; r++) begin
            int sel;
            bit wr;
            sel = $urandom_range(1, 3);
            wr = 1'($urandom_range(0, 1));
            i_pmem_address = $urandom;
            d_pmem_address = $urandom;
            d_pmem_wdata = rand_line();
            run_round(sel[0], sel[1], !wr, wr, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
